mod_mixer_n: RTL and testbench
==============================

Name: mod_mixer_n

Overview:
N-channel oscillator modulation/mixing engine. It is the successor to the two-oscillator combinational modulator.
- Any two of N_OSC oscillator channels are selected as operands A and B.
- One of eight modulation modes is applied, including a new all-channel average mode.
- Output is a registered, left-justified O-bit sample with a valid strobe.
- Sits between the oscillator bank and the output DAC/PWM stage; one computation per sample strobe. AM uses a multi-cycle shift-add multiplier instead of a combinational multiply.

Parameters:
- N_OSC, 4, number of oscillator channels; power of 2, >= 2.
- M, 12, oscillator sample width (unsigned offset-binary).
- O, 16, output width; M <= O <= 2*M.
- SW, $clog2(N_OSC), channel-index width (derived localparam).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sample_en  input  1  start-of-sample strobe
- mode_sel  input  3  modulation mode
- src_a  input  SW  channel index for operand A
- src_b  input  SW  channel index for operand B
- osc_in  input  N_OSC*M  packed channels; channel k = osc_in[k*M +: M]
- mod_out  output  O  modulated sample, left-justified
- out_valid  output  1  one-cycle pulse when mod_out updates
- busy  output  1  high while not IDLE
- overrun  output  1  sticky: sample_en arrived while busy

Behaviour:
- Interface: one clock, clk. Reset is rst: synchronous and active-high.
- Reset values: mod_out=0, out_valid=0, busy=0, overrun=0, FSM=IDLE, multiplier regs=0.
- rst has priority over all events, including mid-computation; the next edge returns to IDLE and discards any partial result.

FSM states: IDLE, CAPTURE, COMPUTE, OUTPUT.
- IDLE: when sample_en=1, register A=osc_in[src_a], B=osc_in[src_b], mode_sel and the full osc_in vector, then go to CAPTURE.
  - All inputs are sampled only at this edge; later changes do not affect the in-flight sample.
- CAPTURE: go to COMPUTE. For AM, load the multiplicand, multiplier and a zero accumulator.
- COMPUTE:
  - Non-AM modes: evaluate in 1 cycle, then go to OUTPUT.
  - AM: perform M shift-add iterations, one per cycle, LSB of B first, then go to OUTPUT.
- OUTPUT: load mod_out, pulse out_valid for exactly 1 cycle, return to IDLE.
- Latency: sample_en high at edge t gives out_valid high in the cycle after edge t+2 (non-AM) or edge t+M+2 (AM). mod_out holds its value until the next OUTPUT.
- sample_en in the same cycle out_valid is high (FSM in OUTPUT) counts as busy and is ignored.
- busy = (state != IDLE).
- sample_en while busy: ignored; overrun set to 1 and held until rst.

Modes. Z = (O-M) zero bits appended below an M-bit result.
- 000 average: ((A+B)>>1), M bits, then Z.
- 001 mid-scale difference: ((A + ~B)>>1), M bits, then (O-M) one bits.
- 010 saturating sum: A+B computed in M+1 bits. On carry, mod_out = all-ones (O bits); otherwise {sum[M-1:0], Z}.
- 011 AM: 2M-bit product A*B; mod_out = product[2M-1 -: O].
- 100 pass A: {A, Z}.
- 101 pass B: {B, Z}.
- 110 XOR: {A^B, Z}.
- 111 all-channel average: sum of all N_OSC captured channels, accumulated at width M+SW, then >> SW. Result is M bits, then Z. src_a and src_b are ignored.

Width rules:
- All arithmetic is unsigned; no intermediate truncation before the stated shifts.
- When O == M, the Z and one-fill fields are empty.

Optional Feature:
- Macro: MOD_MIXER_DITHER_EN.
- When defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) supplies the low (O-M) bits.
  - Applies in modes 000, 010 (non-saturated case), 100, 101, 110 and 111, replacing the zero fill.
  - The LFSR advances once per out_valid pulse.
- When not defined: no LFSR logic; zero fill as specified above.
- Modes 001 and 011 are identical in both builds.

Test Plan (N_OSC=4, M=12, O=16, macro undefined unless stated):
- Mode 000, A=0x800, B=0x400, sample_en at t -> mod_out=0x6000 with out_valid in the cycle after edge t+2; busy high for 3 cycles.
- Mode 010, A=0xC00, B=0x600 -> mod_out=0xFFFF (saturated). Then A=0x300, B=0x200 -> mod_out=0x5000.
- Mode 011, A=0x800, B=0x800 -> mod_out=0x4000, valid at edge t+14. Also A=0xFFF, B=0xFFF -> 0xFFE0.
- Mode 111, channels 0x100/0x200/0x300/0x400 -> mod_out=0x2800; src_a/src_b changes have no effect.
- Overrun/reset: AM start, pulse sample_en at t+4 -> overrun=1, result unaffected. Assert rst at t+6 -> next cycle state IDLE, mod_out=0, busy=0, overrun=0, no out_valid.
- MOD_MIXER_DITHER_EN defined, mode 100, A=0xABC -> mod_out[15:4]=0xABC. Low nibble = LFSR low bits; it differs across two consecutive samples.

Source files
------------

// File: rtl/mod_mixer_n.sv
`default_nettype none
// ============================================================================
//  Module   : mod_mixer_n
//  Purpose  : N-channel oscillator modulation/mixing engine. Two operand
//             channels (or all channels) are combined by one of eight modes
//             into a registered, left-justified O-bit sample with a one-cycle
//             valid strobe. AM uses an M-cycle shift-add multiplier.
//  Options  : define MOD_MIXER_DITHER_EN to replace the zero fill below the
//             M-bit result with bits from a 16-bit Galois LFSR.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_mixer_n #(
    parameter  int N_OSC = 4,
    parameter  int M     = 12,
    parameter  int O     = 16,
    localparam int SW    = $clog2(N_OSC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_en,
    input  logic [2:0]         mode_sel,
    input  logic [SW-1:0]      src_a,
    input  logic [SW-1:0]      src_b,
    input  logic [N_OSC*M-1:0] osc_in,
    output logic [O-1:0]       mod_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_COMPUTE = 2'd2;
    localparam logic [1:0] c_OUTPUT  = 2'd3;

    localparam logic [2:0] c_MODE_AVG  = 3'b000;
    localparam logic [2:0] c_MODE_DIFF = 3'b001;
    localparam logic [2:0] c_MODE_SAT  = 3'b010;
    localparam logic [2:0] c_MODE_AM   = 3'b011;
    localparam logic [2:0] c_MODE_PA   = 3'b100;
    localparam logic [2:0] c_MODE_PB   = 3'b101;
    localparam logic [2:0] c_MODE_XOR  = 3'b110;

    // Iteration counter must be able to hold the value M itself.
    localparam int c_CW = $clog2(M + 1);

    logic [1:0]         r_state;
    logic [2:0]         r_mode;
    logic [M-1:0]       r_a;
    logic [M-1:0]       r_b;
    logic [N_OSC*M-1:0] r_osc;
    logic [2*M-1:0]     r_mcand;
    logic [M-1:0]       r_mplier;
    logic [2*M-1:0]     r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic [O-1:0]       r_mod_out;
    logic               r_out_valid;
    logic               r_overrun;

    logic [M-1:0]       w_ch     [N_OSC];
    logic [M-1:0]       w_cap_ch [N_OSC];
    logic [M:0]         w_sum_ab;
    logic [M:0]         w_diff_ab;
    logic [M+SW-1:0]    w_sum_all;
    logic [M-1:0]       w_zfill;
    logic [M-1:0]       w_res;
    logic [M-1:0]       w_fill;
    logic               w_sat;
    logic [2*M-1:0]     w_wide;
    logic [O-1:0]       w_result;

    // Unpack live and captured channel vectors into per-channel views.
    generate
        for (genvar k = 0; k < N_OSC; k++) begin : g_ch
            assign w_ch[k]     = osc_in[k*M +: M];
            assign w_cap_ch[k] = r_osc[k*M +: M];
        end
    endgenerate

    // Operand sums are one bit wider than the operands so nothing is lost
    // before the halving shift or the saturation test.
    assign w_sum_ab  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff_ab = {1'b0, r_a} + {1'b0, ~r_b};

`ifdef MOD_MIXER_DITHER_EN
    logic [15:0] r_lfsr;

    // Dither source: Galois LFSR x^16+x^14+x^13+x^11+1, stepped once per output pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == c_OUTPUT) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // LFSR low bits placed at the top of the M-bit fill field so they land in
    // mod_out[O-M-1:0] after the final left-justified slice.
    assign w_zfill = M'(r_lfsr) << (2*M - O);
`else
    assign w_zfill = '0;
`endif

    // All-channel sum at M+SW bits; N_OSC M-bit values always fit.
    always_comb begin
        w_sum_all = '0;
        for (int k = 0; k < N_OSC; k++) begin
            w_sum_all = w_sum_all + {{SW{1'b0}}, w_cap_ch[k]};
        end
    end

    // Mode result as an M-bit value plus an M-bit fill, sliced to O bits.
    always_comb begin
        w_res  = '0;
        w_fill = w_zfill;
        w_sat  = 1'b0;
        case (r_mode)
            c_MODE_AVG:  w_res = M'(w_sum_ab >> 1);
            c_MODE_DIFF: begin
                w_res  = M'(w_diff_ab >> 1);
                w_fill = '1;
            end
            c_MODE_SAT: begin
                w_res = M'(w_sum_ab);
                w_sat = w_sum_ab[M];
            end
            c_MODE_AM:   w_fill = '0;
            c_MODE_PA:   w_res = r_a;
            c_MODE_PB:   w_res = r_b;
            c_MODE_XOR:  w_res = r_a ^ r_b;
            default:     w_res = M'(w_sum_all >> SW);
        endcase
        w_wide = {w_res, w_fill};
        if (w_sat) begin
            w_result = '1;
        end else if (r_mode == c_MODE_AM) begin
            w_result = O'(r_acc >> (2*M - O));
        end else begin
            w_result = O'(w_wide >> (2*M - O));
        end
    end

    // Control FSM, operand capture, shift-add multiplier and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_mode      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_osc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mod_out   <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (sample_en && (r_state != c_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (sample_en) begin
                        r_a     <= w_ch[src_a];
                        r_b     <= w_ch[src_b];
                        r_mode  <= mode_sel;
                        r_osc   <= osc_in;
                        r_state <= c_CAPTURE;
                    end
                end
                c_CAPTURE: begin
                    if (r_mode == c_MODE_AM) begin
                        r_mcand  <= {{M{1'b0}}, r_a};
                        r_mplier <= r_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                    r_state <= c_COMPUTE;
                end
                c_COMPUTE: begin
                    if ((r_mode != c_MODE_AM) || (r_cnt == c_CW'(M))) begin
                        r_mod_out   <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= c_OUTPUT;
                    end else begin
                        // One multiplier bit per cycle, LSB first.
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + c_CW'(1);
                    end
                end
                c_OUTPUT: r_state <= c_IDLE;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    assign mod_out   = r_mod_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod_mixer_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_mixer_n
//  Purpose  : Self-checking bench for mod_mixer_n (N_OSC=4, M=12, O=16).
//             Directed cases plus random samples against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_mixer_n;

    localparam int N_OSC = 4;
    localparam int M     = 12;
    localparam int O     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [2:0]  mode_sel = '0;
    logic [1:0]  src_a = '0;
    logic [1:0]  src_b = '0;
    logic [47:0] osc_in = '0;
    logic [15:0] mod_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    mod_mixer_n #(.N_OSC(N_OSC), .M(M), .O(O)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .mode_sel  (mode_sel),
        .src_a     (src_a),
        .src_b     (src_b),
        .osc_in    (osc_in),
        .mod_out   (mod_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int chan(input logic [47:0] osc, input int k);
        return int'((osc >> (k*12)) & 48'hFFF);
    endfunction

    // Low fill the dither build inserts for a mode (zero in the default build).
    function automatic int fill_for(input logic [2:0] md);
`ifdef MOD_MIXER_DITHER_EN
        if (md == 3'd1 || md == 3'd3) return 0;
        return int'(lfsr_m[3:0]);
`else
        return 0;
`endif
    endfunction

    // Reference model: plain integer arithmetic on 12-bit samples, 16-bit out.
    function automatic logic [15:0] model(input logic [2:0] md, input int sa, input int sb,
                                          input logic [47:0] osc, input int dfill);
        int a, b, s, r;
        a = chan(osc, sa);
        b = chan(osc, sb);
        case (md)
            3'd0: r = (((a + b) / 2) * 16) + dfill;
            3'd1: r = (((a + (4095 - b)) / 2) * 16) + 15;
            3'd2: r = (a + b > 4095) ? 32'hFFFF : ((a + b) * 16 + dfill);
            3'd3: r = (a * b) / 256;
            3'd4: r = a * 16 + dfill;
            3'd5: r = b * 16 + dfill;
            3'd6: r = (a ^ b) * 16 + dfill;
            default: begin
                s = 0;
                for (int k = 0; k < 4; k++) s += chan(osc, k);
                r = (s / 4) * 16 + dfill;
            end
        endcase
        return r[15:0];
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Launch one sample and scramble all inputs right after capture.
    task automatic launch(input logic [2:0] md, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [47:0] osc);
        @(negedge clk);
        mode_sel  = md;
        src_a     = sa;
        src_b     = sb;
        osc_in    = osc;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        mode_sel  = 3'($urandom);
        src_a     = 2'($urandom);
        src_b     = 2'($urandom);
        osc_in    = 48'({$urandom(), $urandom()});
    endtask

    task automatic run_sample(input logic [2:0] md, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [47:0] osc, output logic [15:0] got_out);
        logic [15:0] exp;
        int lat;
        bit got;
        exp = model(md, sa, sb, osc, fill_for(md));
        launch(md, sa, sb, osc);
        check("busy_start", busy, 1);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            got = out_valid;
        end
        check($sformatf("latency_m%0d", md), lat, (md == 3'd3) ? 14 : 2);
        check($sformatf("mod_out_m%0d", md), mod_out, exp);
        got_out = mod_out;
        lfsr_m = lfsr_step(lfsr_m);
        @(posedge clk);
        #1;
        check("valid_pulse", out_valid, 0);
        check("busy_idle", busy, 0);
        check("mod_out_hold", mod_out, exp);
    endtask

    initial begin
        logic [15:0] r0, r1;
        int lat, nv;
        bit got;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mod_out", mod_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases; channel 0 = A, channel 1 = B.
        run_sample(3'd0, 2'd0, 2'd1, {12'h0, 12'h0, 12'h400, 12'h800}, r0);
        run_sample(3'd2, 2'd0, 2'd1, {12'h0, 12'h0, 12'h600, 12'hC00}, r0);
        run_sample(3'd2, 2'd2, 2'd3, {12'h200, 12'h300, 12'h0, 12'h0}, r0);
        run_sample(3'd3, 2'd0, 2'd1, {12'h0, 12'h0, 12'h800, 12'h800}, r0);
        run_sample(3'd3, 2'd3, 2'd3, {12'hFFF, 12'h0, 12'h0, 12'h0}, r0);
        run_sample(3'd7, 2'd0, 2'd1, {12'h400, 12'h300, 12'h200, 12'h100}, r0);
        run_sample(3'd7, 2'd3, 2'd2, {12'h400, 12'h300, 12'h200, 12'h100}, r0);
        run_sample(3'd1, 2'd0, 2'd1, {12'h0, 12'h0, 12'hFFF, 12'h000}, r0);
        run_sample(3'd1, 2'd1, 2'd0, {12'h0, 12'h0, 12'h000, 12'hFFF}, r0);
        run_sample(3'd6, 2'd2, 2'd1, {12'h0, 12'h5A5, 12'hFFF, 12'h0}, r0);

`ifdef MOD_MIXER_DITHER_EN
        run_sample(3'd4, 2'd0, 2'd1, {36'h0, 12'hABC}, r0);
        run_sample(3'd4, 2'd0, 2'd1, {36'h0, 12'hABC}, r1);
        check("dither_top", {16'h0, r1[15:4]}, 32'hABC);
        check("dither_diff", (r0[3:0] != r1[3:0]), 1);
`endif

        // Random samples across all modes and channel picks.
        for (int i = 0; i < 40; i++) begin
            run_sample(3'($urandom), 2'($urandom), 2'($urandom),
                       48'({$urandom(), $urandom()}), r0);
        end

        // Overrun during AM: flag goes sticky, in-flight result untouched.
        launch(3'd3, 2'd0, 2'd1, {12'h0, 12'h0, 12'h800, 12'h800});
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        check("overrun_set", overrun, 1);
        lat = 4;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            got = out_valid;
        end
        check("ovr_latency", lat, 14);
        check("ovr_mod_out", mod_out, 16'h4000);
        lfsr_m = lfsr_step(lfsr_m);
        repeat (2) @(posedge clk);
        #1;
        check("overrun_sticky", overrun, 1);

        // Reset mid-AM: everything clears and the partial result never appears.
        launch(3'd3, 2'd0, 2'd1, {12'h0, 12'h0, 12'h7FF, 12'h123});
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        lfsr_m = 16'hACE1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mod_out", mod_out, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) nv++;
        end
        check("no_valid_after_rst", nv, 0);

        // Engine is usable again after the abort.
        run_sample(3'd5, 2'd0, 2'd2, {12'h0, 12'h9C4, 12'h0, 12'h111}, r0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
